// File: rtl/xm23_link_pkg.sv
// Shared types and constants for the terminal-side keyboard/screen link peer.
package xm23_link_pkg;

   localparam int BYTE_W = 8;

   // Bit positions inside link_ctrl_i / link_ctrl_o
   localparam int SCR_REQ = 0;
   localparam int KB_ACK  = 1;
   localparam int SCR_ACK = 0;
   localparam int KB_REQ  = 1;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_ACK  = 1'b1
   } rx_state_t;

   typedef enum logic [1:0] {
      T_IDLE  = 2'd0,
      T_SETUP = 2'd1,
      T_REQ   = 2'd2,
      T_REL   = 2'd3
   } tx_state_t;

endpackage

// File: rtl/link_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; a push into a full FIFO is taken only
// when a pop happens in the same cycle.
module link_byte_fifo
   import xm23_link_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     Clock,
   input  logic                     Reset_n,
   input  logic                     push,
   input  logic [BYTE_W-1:0]        wr_data,
   input  logic                     pop,
   output logic [BYTE_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage is cleared on reset so the head byte reads 0 while empty after reset.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/xm23_link_peer.sv
// Terminal-side peer of the CPU 8-bit keyboard/screen link: two independent
// 4-phase handshakes, each buffered by a small byte FIFO.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   R_IDLE  | scr_ack low; accept a screen byte once s_scr_req and room
//   R_ACK   | scr_ack high; wait for the CPU to drop scr_req
//   T_IDLE  | kb_req low; start when a byte is queued and s_kb_ack is low
//   T_SETUP | link_data_o loaded; setup down-counter running
//   T_REQ   | kb_req high; wait for s_kb_ack, then pop the byte
//   T_REL   | kb_req low; wait for the CPU to drop kb_ack
module xm23_link_peer
   import xm23_link_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int SETUP_CYCLES = 2
) (
   input  logic                          Clock,
   input  logic                          Reset_n,
   input  logic [BYTE_W-1:0]             link_data_i,
   input  logic [1:0]                    link_ctrl_i,
   output logic [BYTE_W-1:0]             link_data_o,
   output logic [1:0]                    link_ctrl_o,
   input  logic [BYTE_W-1:0]             kb_byte,
   input  logic                          kb_valid,
   output logic                          kb_ready,
   output logic [BYTE_W-1:0]             scr_byte,
   output logic                          scr_valid,
   input  logic                          scr_ready,
   output logic                          kb_drop,
   input  logic                          clr_drop,
   output logic [$clog2(FIFO_DEPTH):0]   tx_count,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count
);

   localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

   logic [1:0]  sync_q1;
   logic [1:0]  sync_q2;
   logic        s_scr_req;
   logic        s_kb_ack;

   rx_state_t   rx_state, rx_next;
   tx_state_t   tx_state, tx_next;
   logic        rx_push;
   logic        rx_pop;
   logic        rx_full;
   logic        rx_empty;
   logic        tx_pop;
   logic        tx_load;
   logic        tx_full;
   logic        tx_empty;
   logic [BYTE_W-1:0] tx_head;
   logic [CW-1:0]     setup_cnt, setup_cnt_next;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= link_ctrl_i;
         sync_q2 <= sync_q1;
      end
   end

   assign s_scr_req = sync_q2[SCR_REQ];
   assign s_kb_ack  = sync_q2[KB_ACK];

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         rx_state  <= R_IDLE;
         tx_state  <= T_IDLE;
         setup_cnt <= '0;
      end else begin
         rx_state  <= rx_next;
         tx_state  <= tx_next;
         setup_cnt <= setup_cnt_next;
      end
   end

   // A full RX FIFO holds off the ack, which back-pressures the CPU.
   always_comb begin
      rx_next = rx_state;
      rx_push = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (s_scr_req && !rx_full) begin
               rx_push = 1'b1;
               rx_next = R_ACK;
            end
         end
         R_ACK: begin
            if (!s_scr_req) begin
               rx_next = R_IDLE;
            end
         end
         default: rx_next = R_IDLE;
      endcase
   end

   always_comb begin
      tx_next        = tx_state;
      tx_load        = 1'b0;
      tx_pop         = 1'b0;
      setup_cnt_next = setup_cnt;
      case (tx_state)
         T_IDLE: begin
            if (!tx_empty && !s_kb_ack) begin
               tx_load        = 1'b1;
               setup_cnt_next = CW'(SETUP_CYCLES - 1);
               tx_next        = T_SETUP;
            end
         end
         T_SETUP: begin
            if (setup_cnt == '0) begin
               tx_next = T_REQ;
            end else begin
               setup_cnt_next = setup_cnt - 1'b1;
            end
         end
         T_REQ: begin
            if (s_kb_ack) begin
               tx_pop  = 1'b1;
               tx_next = T_REL;
            end
         end
         T_REL: begin
            if (!s_kb_ack) begin
               tx_next = T_IDLE;
            end
         end
         default: tx_next = T_IDLE;
      endcase
   end

   // The keyboard byte stays on the bus after the handshake; only reset clears it.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         link_data_o <= '0;
      end else if (tx_load) begin
         link_data_o <= tx_head;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         kb_drop <= 1'b0;
      end else if (kb_valid && tx_full && !tx_pop) begin
         kb_drop <= 1'b1;
      end else if (clr_drop) begin
         kb_drop <= 1'b0;
      end
   end

   always_comb begin
      link_ctrl_o          = '0;
      link_ctrl_o[SCR_ACK] = (rx_state == R_ACK);
      link_ctrl_o[KB_REQ]  = (tx_state == T_REQ);
   end

   assign kb_ready  = !tx_full;
   assign scr_valid = !rx_empty;
   assign rx_pop    = scr_ready && scr_valid;

   link_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .push    (kb_valid),
      .wr_data (kb_byte),
      .pop     (tx_pop),
      .rd_data (tx_head),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   link_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .push    (rx_push),
      .wr_data (link_data_i),
      .pop     (rx_pop),
      .rd_data (scr_byte),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

endmodule

// File: tb/tb_xm23_link_peer.sv
// Self-checking bench for xm23_link_peer: vector table plus byte scoreboards
// for both link directions and hand-written handshake corner cases.
module tb_xm23_link_peer;
   import xm23_link_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset_n;
   logic [7:0] link_data_i;
   logic [1:0] link_ctrl_i;
   logic [7:0] link_data_o;
   logic [1:0] link_ctrl_o;
   logic [7:0] kb_byte;
   logic       kb_valid;
   logic       kb_ready;
   logic [7:0] scr_byte;
   logic       scr_valid;
   logic       scr_ready;
   logic       kb_drop;
   logic       clr_drop;
   logic [2:0] tx_count;
   logic [2:0] rx_count;

   logic       scr_req_drv;
   logic       kb_ack_drv;
   logic       cpu_ack_en;
   int         ack_dly;
   int         checks;
   int         errors;

   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];

   typedef struct {
      logic [7:0] rx_data;
      logic [7:0] tx_data;
      int         ack_dly;
      logic [2:0] exp_rx_count;
   } vec_t;

   vec_t vecs[4];

   assign link_ctrl_i = {kb_ack_drv, scr_req_drv};

   always #5 Clock = ~Clock;

   xm23_link_peer #(.FIFO_DEPTH(4), .SETUP_CYCLES(2)) dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .link_data_i (link_data_i),
      .link_ctrl_i (link_ctrl_i),
      .link_data_o (link_data_o),
      .link_ctrl_o (link_ctrl_o),
      .kb_byte     (kb_byte),
      .kb_valid    (kb_valid),
      .kb_ready    (kb_ready),
      .scr_byte    (scr_byte),
      .scr_valid   (scr_valid),
      .scr_ready   (scr_ready),
      .kb_drop     (kb_drop),
      .clr_drop    (clr_drop),
      .tx_count    (tx_count),
      .rx_count    (rx_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic tick(input int k = 1);
      repeat (k) @(posedge Clock);
      #1;
   endtask

   // CPU sending one screen byte through the full 4-phase handshake.
   task automatic cpu_send(input logic [7:0] d, input logic chk_lat);
      int n;
      link_data_i = d;
      scr_req_drv = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!link_ctrl_o[SCR_ACK] && n < 20);
      if (chk_lat) chk("rx_ack_lat", 32'(n), 32'd3);
      else if (n >= 20) fail("rx_ack_timeout");
      scr_req_drv = 1'b0;
      n = 0;
      do begin tick(); n++; end while (link_ctrl_o[SCR_ACK] && n < 20);
      if (chk_lat) chk("rx_rel_lat", 32'(n), 32'd3);
      else if (n >= 20) fail("rx_rel_timeout");
   endtask

   task automatic kb_push(input logic [7:0] d);
      tx_q.push_back(d);
      kb_byte  = d;
      kb_valid = 1'b1;
      tick();
      kb_valid = 1'b0;
   endtask

   task automatic rx_pop_chk();
      chk("rx_valid", 32'(scr_valid), 32'd1);
      if (rx_q.size() == 0) fail("rx_q_empty");
      else chk("rx_byte", 32'(scr_byte), 32'(rx_q.pop_front()));
      scr_ready = 1'b1;
      tick();
      scr_ready = 1'b0;
   endtask

   task automatic wait_tx_idle();
      int n;
      n = 0;
      while ((tx_q.size() != 0 || tx_count != 0 || link_ctrl_o[KB_REQ] || kb_ack_drv) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) fail("tx_idle_timeout");
      tick(4);
   endtask

   // CPU receiving keyboard bytes: checks each byte against the TX scoreboard.
   initial begin : cpu_kb
      int         n;
      logic [7:0] held;
      forever begin
         @(posedge Clock);
         #2;
         if (cpu_ack_en && link_ctrl_o[KB_REQ] && !kb_ack_drv) begin
            held = link_data_o;
            if (tx_q.size() == 0) fail("tx_unexpected_req");
            else begin
               held = tx_q.pop_front();
               chk("tx_byte", 32'(link_data_o), 32'(held));
            end
            repeat (ack_dly) @(posedge Clock);
            #2;
            kb_ack_drv = 1'b1;
            n = 0;
            do begin @(posedge Clock); #2; n++; end while (link_ctrl_o[KB_REQ] && n < 10);
            chk("tx_rel_lat", 32'(n), 32'd3);
            chk("tx_hold", 32'(link_data_o), 32'(held));
            kb_ack_drv = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      Reset_n     = 1'b0;
      link_data_i = '0;
      scr_req_drv = 1'b0;
      kb_ack_drv  = 1'b0;
      kb_byte     = '0;
      kb_valid    = 1'b0;
      scr_ready   = 1'b0;
      clr_drop    = 1'b0;
      cpu_ack_en  = 1'b1;
      ack_dly     = 2;

      vecs[0] = '{8'h48, 8'h31, 1, 3'd1};
      vecs[1] = '{8'hE9, 8'h7F, 3, 3'd2};
      vecs[2] = '{8'h00, 8'hFF, 2, 3'd3};
      vecs[3] = '{8'hFF, 8'h00, 1, 3'd4};

      // Reset values
      tick(2);
      chk("rst_data_o", 32'(link_data_o), 32'h0);
      chk("rst_ctrl_o", 32'(link_ctrl_o), 32'h0);
      chk("rst_kb_ready", 32'(kb_ready), 32'h1);
      chk("rst_scr_byte", 32'(scr_byte), 32'h0);
      chk("rst_scr_valid", 32'(scr_valid), 32'h0);
      chk("rst_kb_drop", 32'(kb_drop), 32'h0);
      chk("rst_tx_count", 32'(tx_count), 32'h0);
      chk("rst_rx_count", 32'(rx_count), 32'h0);
      Reset_n = 1'b1;
      tick(2);

      // RX single byte with exact latencies
      link_data_i = 8'h41;
      scr_req_drv = 1'b1;
      rx_q.push_back(8'h41);
      tick(2);
      chk("rx1_ack_early", 32'(link_ctrl_o[SCR_ACK]), 32'd0);
      chk("rx1_valid_early", 32'(scr_valid), 32'd0);
      tick();
      chk("rx1_ack", 32'(link_ctrl_o[SCR_ACK]), 32'd1);
      chk("rx1_valid", 32'(scr_valid), 32'd1);
      chk("rx1_count", 32'(rx_count), 32'd1);
      scr_req_drv = 1'b0;
      tick(2);
      chk("rx1_ack_hold", 32'(link_ctrl_o[SCR_ACK]), 32'd1);
      tick();
      chk("rx1_ack_fall", 32'(link_ctrl_o[SCR_ACK]), 32'd0);
      rx_pop_chk();
      chk("rx1_drained", 32'(scr_valid), 32'd0);

      // TX sequence 0x0D, 0x0A with exact load/req latencies
      ack_dly = 2;
      tx_q.push_back(8'h0D);
      kb_byte  = 8'h0D;
      kb_valid = 1'b1;
      tick();
      chk("tx_data_before_load", 32'(link_data_o), 32'h0);
      tx_q.push_back(8'h0A);
      kb_byte = 8'h0A;
      tick();
      kb_valid = 1'b0;
      chk("tx_data_load", 32'(link_data_o), 32'h0D);
      chk("tx_count_2", 32'(tx_count), 32'd2);
      chk("tx_req_setup0", 32'(link_ctrl_o[KB_REQ]), 32'd0);
      tick();
      chk("tx_req_setup1", 32'(link_ctrl_o[KB_REQ]), 32'd0);
      tick();
      chk("tx_req_rise", 32'(link_ctrl_o[KB_REQ]), 32'd1);
      begin
         int n;
         n = 0;
         while (tx_count == 3'd2 && n < 60) begin tick(); n++; end
         chk("tx_count_1", 32'(tx_count), 32'd1);
         n = 0;
         while (tx_count == 3'd1 && n < 60) begin tick(); n++; end
         chk("tx_count_0", 32'(tx_count), 32'd0);
      end
      wait_tx_idle();
      chk("tx_data_kept", 32'(link_data_o), 32'h0A);

      // Table: concurrent RX and TX bytes, RX FIFO left filling up
      for (int i = 0; i < 4; i++) begin
         ack_dly = vecs[i].ack_dly;
         rx_q.push_back(vecs[i].rx_data);
         fork
            cpu_send(vecs[i].rx_data, 1'b1);
            kb_push(vecs[i].tx_data);
         join
         chk("vec_rx_count", 32'(rx_count), 32'(vecs[i].exp_rx_count));
         wait_tx_idle();
      end

      // RX back-pressure: 5th byte held off until a pop makes room
      link_data_i = 8'hC3;
      scr_req_drv = 1'b1;
      tick(6);
      chk("bp_ack_held", 32'(link_ctrl_o[SCR_ACK]), 32'd0);
      chk("bp_rx_full", 32'(rx_count), 32'd4);
      rx_q.push_back(8'hC3);
      rx_pop_chk();
      begin
         int n;
         n = 0;
         while (!link_ctrl_o[SCR_ACK] && n < 10) begin tick(); n++; end
         chk("bp_ack", 32'(link_ctrl_o[SCR_ACK]), 32'd1);
         chk("bp_rx_count", 32'(rx_count), 32'd4);
         scr_req_drv = 1'b0;
         n = 0;
         while (link_ctrl_o[SCR_ACK] && n < 10) begin tick(); n++; end
         if (n >= 10) fail("bp_rel_timeout");
      end
      for (int i = 0; i < 4; i++) rx_pop_chk();
      chk("bp_drained", 32'(rx_count), 32'd0);

      // TX overflow with the CPU not acking
      cpu_ack_en = 1'b0;
      tick(5);
      for (int i = 0; i < 5; i++) begin
         kb_byte  = 8'h61 + 8'(i);
         kb_valid = 1'b1;
         if (i < 4) tx_q.push_back(8'h61 + 8'(i));
         tick();
         chk("ovf_drop", 32'(kb_drop), 32'(i == 4));
         chk("ovf_count", 32'(tx_count), (i < 4) ? 32'(i + 1) : 32'd4);
      end
      kb_valid = 1'b0;
      chk("ovf_kb_ready", 32'(kb_ready), 32'd0);
      tick(4);
      chk("ovf_head_on_bus", 32'(link_data_o), 32'h61);
      chk("ovf_req", 32'(link_ctrl_o[KB_REQ]), 32'd1);
      clr_drop = 1'b1;
      tick();
      clr_drop = 1'b0;
      chk("clr_drop", 32'(kb_drop), 32'd0);
      kb_byte  = 8'h70;
      kb_valid = 1'b1;
      clr_drop = 1'b1;
      tick();
      kb_valid = 1'b0;
      clr_drop = 1'b0;
      chk("drop_set_wins", 32'(kb_drop), 32'd1);
      clr_drop = 1'b1;
      tick();
      clr_drop = 1'b0;
      chk("clr_drop_2", 32'(kb_drop), 32'd0);

      // Full TX FIFO: push lands on the same edge as the T_REQ pop
      chk("sim_head", 32'(link_data_o), 32'(tx_q[0]));
      void'(tx_q.pop_front());
      kb_ack_drv = 1'b1;
      tick(2);
      kb_byte  = 8'h66;
      kb_valid = 1'b1;
      tick();
      kb_valid = 1'b0;
      tx_q.push_back(8'h66);
      chk("sim_req_fall", 32'(link_ctrl_o[KB_REQ]), 32'd0);
      chk("sim_no_drop", 32'(kb_drop), 32'd0);
      chk("sim_count", 32'(tx_count), 32'd4);
      kb_ack_drv = 1'b0;
      ack_dly    = 1;
      cpu_ack_en = 1'b1;
      wait_tx_idle();
      chk("sim_drained", 32'(tx_count), 32'd0);

      // Reset in the middle of both handshakes
      cpu_ack_en = 1'b0;
      kb_push(8'h77);
      link_data_i = 8'h55;
      scr_req_drv = 1'b1;
      tick(8);
      chk("mid_kb_req", 32'(link_ctrl_o[KB_REQ]), 32'd1);
      chk("mid_scr_ack", 32'(link_ctrl_o[SCR_ACK]), 32'd1);
      #3;
      Reset_n = 1'b0;
      #1;
      chk("mid_ctrl_o", 32'(link_ctrl_o), 32'd0);
      chk("mid_tx_count", 32'(tx_count), 32'd0);
      chk("mid_rx_count", 32'(rx_count), 32'd0);
      chk("mid_kb_ready", 32'(kb_ready), 32'd1);
      chk("mid_scr_valid", 32'(scr_valid), 32'd0);
      chk("mid_data_o", 32'(link_data_o), 32'd0);
      tx_q.delete();
      scr_req_drv = 1'b0;
      tick(2);
      Reset_n = 1'b1;
      tick(3);
      chk("post_rst_ctrl", 32'(link_ctrl_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
